// File: rtl/cache_miss_gen_if.sv
// rtl/cache_miss_gen_if.sv - CPU request and memory refill signals of the cache miss generator
interface cache_miss_gen_if #(
  parameter int ADDR_WIDTH  = 8,
  parameter int OFFSET_BITS = 2
);
  logic                          read;
  logic                          write;
  logic [ADDR_WIDTH-1:0]         address;
  logic                          busywait;
  logic                          hit;
  logic                          miss;
  logic                          mem_read;
  logic [ADDR_WIDTH-OFFSET_BITS-1:0] mem_address;
  logic                          mem_busywait;

  modport slave (
    input  read, write, address, mem_busywait,
    output busywait, hit, miss, mem_read, mem_address
  );

  modport master (
    output read, write, address, mem_busywait,
    input  busywait, hit, miss, mem_read, mem_address
  );
endinterface

// File: rtl/cache_miss_gen.sv
// rtl/cache_miss_gen.sv - direct-mapped tag lookup and refill controller emitting one miss pulse per refill
module cache_miss_gen #(
  parameter int ADDR_WIDTH  = 8,
  parameter int INDEX_BITS  = 3,
  parameter int OFFSET_BITS = 2
) (
  input  logic             clock,
  input  logic             init,
  cache_miss_gen_if.slave  bus
);
  localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS;
  localparam int LINES    = 1 << INDEX_BITS;
  localparam int BLK_BITS = ADDR_WIDTH - OFFSET_BITS;

  typedef enum logic [1:0] {IDLE, FETCH, UPDATE} state_t;

  state_t                state, state_nxt;
  logic [LINES-1:0]      valid;
  logic [TAG_BITS-1:0]   tags [LINES];
  logic [BLK_BITS-1:0]   fetch_blk;
  logic                  miss_q;

  logic                  req;
  logic [TAG_BITS-1:0]   tag;
  logic [INDEX_BITS-1:0] idx;
  logic                  lookup_hit;
  logic                  start_fetch;
  logic                  hit_c, busy_c, mem_read_c;
  logic [BLK_BITS-1:0]   mem_addr_c;
  logic                  unused_offset;

  // Lookups are suppressed while init is high so no output rises during reset.
  assign req           = (bus.read | bus.write) & ~init;
  assign tag           = bus.address[ADDR_WIDTH-1 -: TAG_BITS];
  assign idx           = bus.address[OFFSET_BITS +: INDEX_BITS];
  assign lookup_hit    = valid[idx] && (tags[idx] == tag);
  assign start_fetch   = (state == IDLE) && req && !lookup_hit;
  assign unused_offset = &{1'b0, bus.address[OFFSET_BITS-1:0]};

  always_ff @(posedge clock or posedge init) begin
    if (init) begin
      state     <= IDLE;
      valid     <= '0;
      fetch_blk <= '0;
      miss_q    <= 1'b0;
    end else begin
      state  <= state_nxt;
      miss_q <= start_fetch;
      if (start_fetch)
        fetch_blk <= {tag, idx};
      if (state == UPDATE)
        valid[fetch_blk[INDEX_BITS-1:0]] <= 1'b1;
    end
  end

  // Tags need no reset: a line is only trusted once its valid bit is set.
  always_ff @(posedge clock) begin
    if (state == UPDATE)
      tags[fetch_blk[INDEX_BITS-1:0]] <= fetch_blk[BLK_BITS-1 -: TAG_BITS];
  end

  always_comb begin
    state_nxt  = state;
    hit_c      = 1'b0;
    busy_c     = 1'b0;
    mem_read_c = 1'b0;
    mem_addr_c = '0;
    case (state)
      IDLE: begin
        if (req) begin
          if (lookup_hit) begin
            hit_c = 1'b1;
          end else begin
            busy_c    = 1'b1;
            state_nxt = FETCH;
          end
        end
      end
      FETCH: begin
        busy_c     = 1'b1;
        mem_read_c = 1'b1;
        mem_addr_c = fetch_blk;
        if (!bus.mem_busywait)
          state_nxt = UPDATE;
      end
      UPDATE: begin
        busy_c    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.hit         = hit_c;
  assign bus.busywait    = busy_c;
  assign bus.miss        = miss_q;
  assign bus.mem_read    = mem_read_c;
  assign bus.mem_address = mem_addr_c;
endmodule

// File: tb/tb_cache_miss_gen.sv
// tb/tb_cache_miss_gen.sv - self-checking bench for cache_miss_gen
module tb_cache_miss_gen;
  logic clock = 1'b0;
  logic init;
  always #5 clock = ~clock;

  cache_miss_gen_if bi ();
  cache_miss_gen dut (.clock(clock), .init(init), .bus(bi));

  typedef struct {
    logic [7:0] addr;
    bit         rd;
    bit         wr;
    int         lat;
    bit         drop;
    bit         exp_hit;
    int         exp_misses;
  } vec_t;

  vec_t       tbl [$];
  int         checks = 0;
  int         errors = 0;
  int         seen_misses = 0;
  int         model_misses = 0;
  bit         mvalid [8];
  logic [2:0] mtag [8];
  logic [9:0] obs;

  task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [9:0] ev(input bit h, input bit b, input bit m, input bit r, input logic [5:0] ma);
    return {h, b, m, r, ma};
  endfunction

  // One clock: drive in the low phase, sample just after, edge follows.
  task automatic step(input bit rd, input bit wr, input logic [7:0] a, input bit mbw);
    @(negedge clock);
    bi.read = rd;
    bi.write = wr;
    bi.address = a;
    bi.mem_busywait = mbw;
    #1;
    obs = {bi.hit, bi.busywait, bi.miss, bi.mem_read, bi.mem_address};
    if (bi.miss === 1'b1) seen_misses++;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++) mvalid[i] = 1'b0;
  endtask

  // Full transaction against the line model: hit in one cycle, or
  // detect + lat fetch cycles + update + (unless dropped) the hit cycle.
  task automatic access(input logic [7:0] a, input bit rd, input bit wr, input int lat,
                        input bit drop, output bit got_hit);
    logic [2:0] tg;
    logic [2:0] ix;
    bit         exp_hit;
    tg = a[7:5];
    ix = a[4:2];
    exp_hit = mvalid[ix] && (mtag[ix] == tg);
    step(rd, wr, a, 1'b1);
    got_hit = obs[9];
    if (exp_hit) begin
      chk("hit", obs, ev(1, 0, 0, 0, 6'h0));
    end else begin
      chk("miss_detect", obs, ev(0, 1, 0, 0, 6'h0));
      model_misses++;
      for (int k = 0; k < lat; k++) begin
        step((drop && k > 0) ? 1'b0 : rd, (drop && k > 0) ? 1'b0 : wr, a, (k == lat - 1) ? 1'b0 : 1'b1);
        chk("fetch", obs, ev(0, 1, k == 0, 1, a[7:2]));
      end
      step(drop ? 1'b0 : rd, drop ? 1'b0 : wr, a, 1'b1);
      chk("update", obs, ev(0, 1, 0, 0, 6'h0));
      mvalid[ix] = 1'b1;
      mtag[ix] = tg;
      if (!drop) begin
        step(rd, wr, a, 1'b1);
        chk("refill_hit", obs, ev(1, 0, 0, 0, 6'h0));
      end
    end
  endtask

  task automatic run_table();
    bit h;
    foreach (tbl[i]) begin
      access(tbl[i].addr, tbl[i].rd, tbl[i].wr, tbl[i].lat, tbl[i].drop, h);
      chk($sformatf("tbl_hit[%0d]", i), {9'b0, h}, {9'b0, tbl[i].exp_hit});
      chk($sformatf("tbl_misses[%0d]", i), 10'(seen_misses), 10'(tbl[i].exp_misses));
    end
    tbl.delete();
  endtask

  initial begin
    bit h;
    init = 1'b1;
    bi.read = 1'b0;
    bi.write = 1'b0;
    bi.address = 8'h00;
    bi.mem_busywait = 1'b1;
    clear_model();
    repeat (2) @(negedge clock);
    #1;
    chk("reset_outputs", {bi.hit, bi.busywait, bi.miss, bi.mem_read, bi.mem_address}, 10'h0);
    @(negedge clock);
    init = 1'b0;

    // Cold read, same-block hits, index conflict and re-miss.
    tbl.push_back('{8'h14, 1, 0, 3, 0, 0, 1});
    tbl.push_back('{8'h15, 1, 0, 1, 0, 1, 1});
    tbl.push_back('{8'h17, 0, 1, 1, 0, 1, 1});
    tbl.push_back('{8'h34, 1, 0, 2, 0, 0, 2});
    tbl.push_back('{8'h14, 1, 0, 1, 0, 0, 3});
    tbl.push_back('{8'h14, 1, 1, 1, 0, 1, 3});
    run_table();

    // Reset asserted during the second fetch cycle of a miss on 0x20.
    step(1, 0, 8'h20, 1'b1);
    chk("rst_detect", obs, ev(0, 1, 0, 0, 6'h0));
    step(1, 0, 8'h20, 1'b1);
    chk("rst_fetch1", obs, ev(0, 1, 1, 1, 6'h08));
    model_misses++;
    @(negedge clock);
    init = 1'b1;
    #1;
    chk("rst_async_drop", {bi.hit, bi.busywait, bi.miss, bi.mem_read, bi.mem_address}, 10'h0);
    @(negedge clock);
    #1;
    chk("rst_held", {bi.hit, bi.busywait, bi.miss, bi.mem_read, bi.mem_address}, 10'h0);
    init = 1'b0;
    bi.read = 1'b0;
    clear_model();

    // After reset 0x14 misses again; dropped request on 0x40 still refills.
    tbl.push_back('{8'h14, 1, 0, 2, 0, 0, 5});
    tbl.push_back('{8'h40, 1, 0, 2, 1, 0, 6});
    tbl.push_back('{8'h40, 1, 0, 1, 0, 1, 6});
    tbl.push_back('{8'h14, 0, 1, 1, 0, 1, 6});
    run_table();

    for (int i = 0; i < 10; i++) begin
      step(0, 0, 8'($urandom), 1'($urandom));
      chk("idle", obs, 10'h0);
    end

    for (int i = 0; i < 60; i++) begin
      logic [7:0] a;
      logic [1:0] kind;
      a = {3'($urandom_range(0, 1)), 3'($urandom_range(0, 3)), 2'($urandom)};
      kind = 2'($urandom_range(1, 3));
      access(a, kind[0], kind[1], $urandom_range(1, 4), $urandom_range(0, 7) == 0, h);
    end

    chk("total_misses", 10'(seen_misses), 10'(model_misses));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
